// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the mfc0 read mux.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IM_LO   = 10;
  localparam int unsigned IM_HI   = 15;
  localparam int unsigned IP_LO   = 10;
  localparam int unsigned IP_HI   = 15;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned EXC_LO  = 2;
  localparam int unsigned EXC_HI  = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Unmapped register numbers read as zero.
  function automatic logic [31:0] read_mux(input logic [4:0]  a,
                                           input logic [31:0] sr,
                                           input logic [31:0] cause,
                                           input logic [31:0] epc,
                                           input logic [31:0] prid);
    logic [31:0] d;
    d = 32'd0;
    case (a)
      REG_SR:    d = sr;
      REG_CAUSE: d = cause;
      REG_EPC:   d = epc;
      REG_PRID:  d = prid;
      default:   d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0: interrupt/exception entry decision, SR/Cause/EPC/PRId state,
// mfc0/mtc0 access and EPC export for eret.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h4255_4141,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_out,
  output logic [31:0] Dout,
  output logic [31:0] Vector
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int;
  logic        w_exc;
  logic [31:0] w_epc_entry;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc;

  // Architectural views; forced to reset values while reset is held.
  assign w_sr    = reset ? 32'd0 : {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = reset ? 32'd0 : {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
  assign w_epc   = reset ? 32'd0 : r_epc;

  assign w_int       = r_ie & (|(HWInt & r_im));
  assign w_exc       = (ExcCode_in != EXC_INT);
  assign w_epc_entry = (BD ? (PC - 32'd4) : PC) & ~32'h3;

  assign IntReq  = ~reset & ~r_exl & (w_int | w_exc);
  assign EPC_out = w_epc;
  assign Dout    = read_mux(A1, w_sr, w_cause, w_epc, PRID);
  assign Vector  = HANDLER_PC;

  // Entry beats mtc0 (the writer is flushed); EXLClr beats an SR write of EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (IntReq) begin
        r_exl     <= 1'b1;
        r_bd      <= BD;
        r_epc     <= w_epc_entry;
        r_exccode <= w_int ? EXC_INT : ExcCode_in;
      end else begin
        if (WE) begin
          case (A2)
            REG_SR: begin
              r_im  <= Din[IM_HI:IM_LO];
              r_exl <= Din[EXL_BIT];
              r_ie  <= Din[IE_BIT];
            end
            REG_EPC: r_epc <= Din & ~32'h3;
            default: ;
          endcase
        end
        if (EXLClr) r_exl <= 1'b0;
      end
    end
  end

endmodule
